nav_command_sequencer: RTL and testbench
========================================

Name: nav_command_sequencer

Overview:
Sequences the motor direction controller through a stored path program. A small register-file program holds up to DEPTH steps. Each step is STRAIGHT, TURN_RIGHT or TURN_LEFT with a compare distance. The block drives COMMAND/COMPARE_DISTANCE into the direction controller, tracks its RUN_FLAG handshake (INI/EXC/COM/ERR), inserts a neutral gap between steps, and supervises each step with ack and run timeouts.

Parameters:
DEPTH, 16, number of program entries
ADDR_W, 4, index width; must equal clog2(DEPTH)
ACK_TIMEOUT, 16, max cycles from command issue to RUN_FLAG==EXC
RUN_TIMEOUT, 10000000, max cycles in EXC before RUN_FLAG==COM (24-bit counter)
GAP_CYCLES, 8, cycles COMMAND is held at 8'h00 between steps

Ports:
CLK  in  1  system clock
RST  in  1  synchronous, active-high reset
PROG_WE  in  1  program write strobe; ignored while BUSY
PROG_ADDR  in  ADDR_W  program write index
PROG_DATA  in  10  {opcode[1:0], distance[7:0]}; opcode 00=END, 01=STRAIGHT, 10=TURN_RIGHT, 11=TURN_LEFT
START  in  1  pulse; begins at index 0 when in IDLE, DONE or ERROR
ABORT  in  1  level/pulse; highest priority, returns to IDLE
RUN_FLAG  in  2  direction-controller status: 00 INI, 01 EXC, 10 COM, 11 ERR
COMMAND  out  8  8'h00 idle, 8'h0C STRAIGHT, 8'h0E TURN_LEFT, 8'h0F TURN_RIGHT
COMPARE_DISTANCE  out  8  distance field of the active step, else 0
STEP_INDEX  out  ADDR_W  index of the active or last step
BUSY  out  1  high in FETCH/WAIT_ACK/WAIT_DONE/GAP
DONE  out  1  high in DONE state
ERR_CODE  out  2  00 none, 01 ack timeout, 10 run timeout, 11 RUN_ERR seen

Behaviour:
- Reset value of every output is 0. State goes to IDLE, timers clear, and ERR_CODE is 00. Program contents are NOT cleared by RST.
- All outputs are registered. COMMAND changes one cycle after the state transition that selects it.
- States: IDLE, FETCH, WAIT_ACK, WAIT_DONE, GAP, DONE, ERROR.
- IDLE/DONE/ERROR + START: STEP_INDEX=0, ERR_CODE=00, go to FETCH.
- FETCH (1 cycle): read entry[STEP_INDEX].
  - opcode END: go to DONE with COMMAND=0.
  - otherwise: load COMMAND and COMPARE_DISTANCE, clear timer, go to WAIT_ACK.
- WAIT_ACK:
  - RUN_FLAG==EXC: go to WAIT_DONE and clear timer.
  - INI and COM are ignored here. The previous step leaves RUN_FLAG at COM and the controller passes COM to INI to EXC.
  - timer reaches ACK_TIMEOUT: go to ERROR, ERR_CODE=01.
- WAIT_DONE:
  - RUN_FLAG==COM: COMMAND=0, go to GAP, clear timer.
  - timer reaches RUN_TIMEOUT: go to ERROR, ERR_CODE=10.
- RUN_FLAG==ERR in WAIT_ACK or WAIT_DONE: go to ERROR, ERR_CODE=11. This takes precedence over a timeout in the same cycle.
- GAP: hold COMMAND=0 for GAP_CYCLES cycles, then:
  - STEP_INDEX==DEPTH-1: go to DONE.
  - else: STEP_INDEX+1, go to FETCH.
- ERROR: COMMAND=0, COMPARE_DISTANCE=0. ERR_CODE and STEP_INDEX are held until START or ABORT.
- ABORT in any state: next cycle state=IDLE, COMMAND=0, BUSY=0, DONE=0, ERR_CODE=00, STEP_INDEX held. ABORT wins over a simultaneous START.
- PROG_WE while BUSY is dropped. PROG_WE and START in the same cycle: the write lands first, and FETCH sees the new data.
- Timers saturate and do not wrap. Comparisons are unsigned.
- RST mid-step drops COMMAND to 0 on the next edge. Any in-flight controller state is not tracked.

Decomposition:
- Shared package nav_pkg holds:
  - RUN_FLAG encodings (RUN_INI/EXC/COM/ERR)
  - COMMAND codes (CMD_IDLE, CMD_STRAIGHT, CMD_TURN_LEFT, CMD_TURN_RIGHT)
  - opcode encodings
  - ERR_CODE values
- One natural sub-module: nav_step_timer, a 24-bit clearable saturating counter with a compare output. It is instantiated once and reused for the ACK, RUN and GAP phases.
- Program store is inline register array.

Test Plan:
- Single step: program [STRAIGHT,140],[END]; START; model answers EXC after 3 cycles and COM after 50 cycles. Required: COMMAND=8'h0C with COMPARE_DISTANCE=140 until COM, then 0. DONE after GAP and one FETCH. ERR_CODE=00.
- Three steps: STRAIGHT, TURN_RIGHT, TURN_LEFT. Model holds COM between steps until the next command. Required: COMMAND sequence 0C, 00×8, 0F, 00×8, 0E. STEP_INDEX 0, 1, 2. DONE.
- Ack timeout: model keeps RUN_FLAG=COM. Required: ERROR after 16 cycles, ERR_CODE=01, COMMAND=0, STEP_INDEX=0.
- RUN_ERR: model drives 11 during step 1 WAIT_DONE. Required: next cycle ERROR, ERR_CODE=11, STEP_INDEX=1. A following START restarts at index 0 with ERR_CODE cleared.
- Abort and write lockout: ABORT during WAIT_DONE gives IDLE and COMMAND=0 next cycle. PROG_WE while BUSY leaves the entry unchanged.
- Full program: 16 non-END entries. Required: DONE after index 15 with no wrap to 0. RST mid-run clears all outputs but the program is retained.

Source files
------------

// File: rtl/nav_pkg.sv
// nav_pkg: shared encodings for the navigation command sequencer.
package nav_pkg;

    // Direction-controller RUN_FLAG status
    localparam logic [1:0] RUN_INI = 2'b00;
    localparam logic [1:0] RUN_EXC = 2'b01;
    localparam logic [1:0] RUN_COM = 2'b10;
    localparam logic [1:0] RUN_ERR = 2'b11;

    // COMMAND codes driven to the direction controller
    localparam logic [7:0] CMD_IDLE       = 8'h00;
    localparam logic [7:0] CMD_STRAIGHT   = 8'h0C;
    localparam logic [7:0] CMD_TURN_LEFT  = 8'h0E;
    localparam logic [7:0] CMD_TURN_RIGHT = 8'h0F;

    // Program opcodes, stored in PROG_DATA[9:8]
    localparam logic [1:0] OP_END        = 2'b00;
    localparam logic [1:0] OP_STRAIGHT   = 2'b01;
    localparam logic [1:0] OP_TURN_RIGHT = 2'b10;
    localparam logic [1:0] OP_TURN_LEFT  = 2'b11;

    // ERR_CODE values
    localparam logic [1:0] ERRC_NONE    = 2'b00;
    localparam logic [1:0] ERRC_ACK_TO  = 2'b01;
    localparam logic [1:0] ERRC_RUN_TO  = 2'b10;
    localparam logic [1:0] ERRC_RUN_ERR = 2'b11;

    // Shared phase timer width (wide enough for the run timeout)
    localparam int TIMER_W = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_GAP,
        ST_DONE,
        ST_ERROR
    } state_e;

    // Map a step opcode onto the controller command byte
    function automatic logic [7:0] op_to_cmd(input logic [1:0] op);
        logic [7:0] cmd;
        case (op)
            OP_STRAIGHT:   cmd = CMD_STRAIGHT;
            OP_TURN_RIGHT: cmd = CMD_TURN_RIGHT;
            OP_TURN_LEFT:  cmd = CMD_TURN_LEFT;
            default:       cmd = CMD_IDLE;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/nav_step_timer.sv
// nav_step_timer: clearable saturating phase counter with a >= limit compare.
module nav_step_timer
    import nav_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    input  logic [TIMER_W-1:0] limit_i,
    output logic               hit_o
);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and stick at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q != {TIMER_W{1'b1}}) begin
            cnt_d = cnt_q + TIMER_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q >= limit_i);

endmodule

// File: rtl/nav_command_sequencer.sv
// nav_command_sequencer: steps the direction controller through a stored
// path program, supervising the RUN_FLAG handshake of every step.
module nav_command_sequencer
    import nav_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int ACK_TIMEOUT = 16,
    parameter int RUN_TIMEOUT = 10000000,
    parameter int GAP_CYCLES  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PROG_WE,
    input  logic [ADDR_W-1:0] PROG_ADDR,
    input  logic [9:0]        PROG_DATA,
    input  logic              START,
    input  logic              ABORT,
    input  logic [1:0]        RUN_FLAG,
    output logic [7:0]        COMMAND,
    output logic [7:0]        COMPARE_DISTANCE,
    output logic [ADDR_W-1:0] STEP_INDEX,
    output logic              BUSY,
    output logic              DONE,
    output logic [1:0]        ERR_CODE
);

    // Timer limits are "last cycle" counts: the timer reads 0 on the first
    // cycle of a phase. GAP is one short because the FETCH cycle that follows
    // also holds COMMAND idle, giving GAP_CYCLES neutral cycles in total.
    localparam logic [TIMER_W-1:0] ACK_LIMIT = TIMER_W'(ACK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] RUN_LIMIT = TIMER_W'(RUN_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] GAP_LIMIT = TIMER_W'(GAP_CYCLES - 2);
    localparam logic [ADDR_W-1:0]  LAST_IDX  = ADDR_W'(DEPTH - 1);

    logic [9:0]         prog_q [DEPTH];
    logic [9:0]         entry;

    state_e             state_q, state_d;
    logic [7:0]         cmd_q, cmd_d;
    logic [7:0]         dist_q, dist_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [1:0]         err_q, err_d;

    logic               tmr_clr;
    logic               tmr_hit;
    logic [TIMER_W-1:0] tmr_limit;

    assign entry = prog_q[idx_q];

    // Program store; writes are locked out while a program is running
    always_ff @(posedge CLK) begin
        if (PROG_WE && !busy_q) begin
            prog_q[PROG_ADDR] <= PROG_DATA;
        end
    end

    // Select the timeout that applies to the current phase
    always_comb begin
        tmr_limit = {TIMER_W{1'b1}};
        case (state_q)
            ST_WAIT_ACK:  tmr_limit = ACK_LIMIT;
            ST_WAIT_DONE: tmr_limit = RUN_LIMIT;
            ST_GAP:       tmr_limit = GAP_LIMIT;
            default:      tmr_limit = {TIMER_W{1'b1}};
        endcase
    end

    nav_step_timer u_timer (
        .clk_i   (CLK),
        .rst_i   (RST),
        .clr_i   (tmr_clr),
        .limit_i (tmr_limit),
        .hit_o   (tmr_hit)
    );

    // Next-state and registered-output decode
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        dist_d  = dist_q;
        idx_d   = idx_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (START) begin
                    idx_d   = '0;
                    err_d   = ERRC_NONE;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (entry[9:8] == OP_END) begin
                    cmd_d   = CMD_IDLE;
                    dist_d  = '0;
                    state_d = ST_DONE;
                end else begin
                    cmd_d   = op_to_cmd(entry[9:8]);
                    dist_d  = entry[7:0];
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                // INI/COM are the controller still finishing the last step
                if (RUN_FLAG == RUN_ERR) begin
                    err_d   = ERRC_RUN_ERR;
                    state_d = ST_ERROR;
                end else if (RUN_FLAG == RUN_EXC) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmr_hit) begin
                    err_d   = ERRC_ACK_TO;
                    state_d = ST_ERROR;
                end
            end
            ST_WAIT_DONE: begin
                if (RUN_FLAG == RUN_ERR) begin
                    err_d   = ERRC_RUN_ERR;
                    state_d = ST_ERROR;
                end else if (RUN_FLAG == RUN_COM) begin
                    cmd_d   = CMD_IDLE;
                    dist_d  = '0;
                    state_d = ST_GAP;
                end else if (tmr_hit) begin
                    err_d   = ERRC_RUN_TO;
                    state_d = ST_ERROR;
                end
            end
            ST_GAP: begin
                if (tmr_hit) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_ERROR) begin
            cmd_d  = CMD_IDLE;
            dist_d = '0;
        end

        // Abort overrides everything, including a same-cycle START
        if (ABORT) begin
            state_d = ST_IDLE;
            cmd_d   = CMD_IDLE;
            dist_d  = '0;
            err_d   = ERRC_NONE;
            idx_d   = idx_q;
        end

        busy_d  = (state_d inside {ST_FETCH, ST_WAIT_ACK, ST_WAIT_DONE, ST_GAP});
        done_d  = (state_d == ST_DONE);
        tmr_clr = (state_d != state_q);
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_IDLE;
            dist_q  <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= ERRC_NONE;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            dist_q  <= dist_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign COMMAND          = cmd_q;
    assign COMPARE_DISTANCE = dist_q;
    assign STEP_INDEX       = idx_q;
    assign BUSY             = busy_q;
    assign DONE             = done_q;
    assign ERR_CODE         = err_q;

endmodule

// File: tb/tb_nav_command_sequencer.sv
// tb_nav_command_sequencer: randomized program runs against a step-level
// expectation model and a simple direction-controller responder.
module tb_nav_command_sequencer;

    localparam int NSTEP  = 16;
    localparam int ACK_TO = 16;
    localparam int RUN_TO = 200;

    localparam int B_NORMAL = 0;
    localparam int B_NOACK  = 1;
    localparam int B_ERR    = 2;
    localparam int B_NORUN  = 3;
    localparam int B_ABORT  = 4;

    logic       CLK = 1'b0;
    logic       RST;
    logic       PROG_WE;
    logic [3:0] PROG_ADDR;
    logic [9:0] PROG_DATA;
    logic       START;
    logic       ABORT;
    logic [1:0] RUN_FLAG;
    logic [7:0] COMMAND;
    logic [7:0] COMPARE_DISTANCE;
    logic [3:0] STEP_INDEX;
    logic       BUSY;
    logic       DONE;
    logic [1:0] ERR_CODE;

    nav_command_sequencer #(
        .DEPTH       (16),
        .ADDR_W      (4),
        .ACK_TIMEOUT (ACK_TO),
        .RUN_TIMEOUT (RUN_TO),
        .GAP_CYCLES  (8)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .PROG_WE          (PROG_WE),
        .PROG_ADDR        (PROG_ADDR),
        .PROG_DATA        (PROG_DATA),
        .START            (START),
        .ABORT            (ABORT),
        .RUN_FLAG         (RUN_FLAG),
        .COMMAND          (COMMAND),
        .COMPARE_DISTANCE (COMPARE_DISTANCE),
        .STEP_INDEX       (STEP_INDEX),
        .BUSY             (BUSY),
        .DONE             (DONE),
        .ERR_CODE         (ERR_CODE)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference program image and per-step controller behaviour
    logic [9:0] prog_m [NSTEP];
    int         beh    [NSTEP];
    int         ack_l  [NSTEP];
    int         run_l  [NSTEP];
    int         x_l    [NSTEP];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int cmd_of(input logic [1:0] op);
        case (op)
            2'b01:   return 8'h0C;
            2'b10:   return 8'h0F;
            2'b11:   return 8'h0E;
            default: return 0;
        endcase
    endfunction

    // nsteps runnable entries, then END (if room), rest random
    task automatic fill_prog(input int nsteps);
        for (int i = 0; i < NSTEP; i++) begin
            prog_m[i] = {2'($urandom_range(1, 3)), 8'($urandom)};
            beh[i]    = B_NORMAL;
            ack_l[i]  = $urandom_range(1, 8);
            run_l[i]  = $urandom_range(2, 30);
            x_l[i]    = $urandom_range(1, run_l[i] - 1);
        end
        if (nsteps < NSTEP) prog_m[nsteps] = {2'b00, 8'($urandom)};
    endtask

    task automatic load_all();
        for (int i = 0; i < NSTEP; i++) begin
            @(negedge CLK);
            PROG_WE   = 1'b1;
            PROG_ADDR = 4'(i);
            PROG_DATA = prog_m[i];
        end
        @(negedge CLK);
        PROG_WE = 1'b0;
    endtask

    task automatic run_scn(input string name, input bit wr_at_start);
        int e_cmd[$], e_dist[$], e_idx[$], e_len[$];
        int r_cmd[$], r_dist[$], r_idx[$], r_len[$], r_gap[$];
        int e_end, e_err, e_fidx, e_trail, poke_addr;
        int seg, k, zeros, cyc, lead, si, b;
        bit prev_nz, stable, fin, aborted;
        logic [9:0] nd;

        RUN_FLAG = 2'b10;
        @(negedge CLK);
        START = 1'b1;
        if (wr_at_start) begin
            nd        = {2'($urandom_range(1, 3)), 8'($urandom)};
            PROG_WE   = 1'b1;
            PROG_ADDR = 4'd0;
            PROG_DATA = nd;
            prog_m[0] = nd;
        end

        // Step-level expectation from the program and controller behaviour
        e_end = 0; e_err = 0; e_fidx = 0; e_trail = 8;
        for (int i = 0; i < NSTEP; i++) begin
            if (prog_m[i][9:8] == 2'b00) begin
                e_fidx  = i;
                e_trail = (i == 0) ? 1 : 8;
                break;
            end
            e_cmd.push_back(cmd_of(prog_m[i][9:8]));
            e_dist.push_back(int'(prog_m[i][7:0]));
            e_idx.push_back(i);
            case (beh[i])
                B_NOACK: begin e_len.push_back(ACK_TO);           e_end = 1; e_err = 1; end
                B_ERR:   begin e_len.push_back(ack_l[i] + x_l[i]); e_end = 1; e_err = 3; end
                B_NORUN: begin e_len.push_back(ack_l[i] + RUN_TO); e_end = 1; e_err = 2; end
                B_ABORT: begin e_len.push_back(ack_l[i] + x_l[i]); e_end = 2; end
                default: e_len.push_back(ack_l[i] + run_l[i]);
            endcase
            if (beh[i] != B_NORMAL) begin
                e_fidx  = i;
                e_trail = 0;
                break;
            end
            if (i == NSTEP - 1) begin
                e_fidx  = i;
                e_trail = 7;
            end
        end
        poke_addr = (e_end == 0) ? e_fidx : e_idx[e_idx.size() - 1];

        @(negedge CLK);
        START   = 1'b0;
        PROG_WE = 1'b0;
        check({name, ".start_busy"}, BUSY, 1);
        check({name, ".start_idx"}, STEP_INDEX, 0);
        check({name, ".start_err"}, ERR_CODE, 0);

        seg = -1; k = 0; zeros = 0; cyc = 0; lead = 0;
        prev_nz = 0; stable = 1; fin = 0; aborted = 0;
        while (!fin && cyc < 5000) begin
            cyc++;
            PROG_WE = 1'b0;
            if (aborted) begin
                ABORT = 1'b0;
                fin   = 1;
            end else if (COMMAND != 8'h00) begin
                if (!prev_nz) begin
                    seg++;
                    if (seg > 0) r_gap.push_back(zeros);
                    else lead = zeros;
                    zeros = 0;
                    k = 0;
                    r_cmd.push_back(int'(COMMAND));
                    r_dist.push_back(int'(COMPARE_DISTANCE));
                    r_idx.push_back(int'(STEP_INDEX));
                    r_len.push_back(0);
                end else if (int'(COMMAND) != r_cmd[seg] || int'(COMPARE_DISTANCE) != r_dist[seg]
                             || int'(STEP_INDEX) != r_idx[seg]) begin
                    stable = 0;
                end
                k++;
                r_len[seg] = k;
                si = (seg < e_idx.size()) ? e_idx[seg] : 0;
                b  = (seg < e_idx.size()) ? beh[si] : B_NORMAL;
                if (b == B_NOACK) RUN_FLAG = 2'b10;
                else if (b == B_NORMAL && k >= ack_l[si] + run_l[si]) RUN_FLAG = 2'b10;
                else if (b == B_ERR && k >= ack_l[si] + x_l[si]) RUN_FLAG = 2'b11;
                else if (k >= ack_l[si]) RUN_FLAG = 2'b01;
                else RUN_FLAG = 2'b00;
                if (b == B_ABORT && k == ack_l[si] + x_l[si]) begin
                    ABORT   = 1'b1;
                    aborted = 1;
                end
                if (seg == 0 && k == 2) begin
                    PROG_WE   = 1'b1;
                    PROG_ADDR = 4'(poke_addr);
                    PROG_DATA = prog_m[poke_addr] ^ 10'h3FF;
                end
                prev_nz = 1;
            end else begin
                prev_nz = 0;
                if (DONE || ERR_CODE != 2'b00) fin = 1;
                else zeros++;
            end
            if (!fin) @(negedge CLK);
        end

        if (!fin) check({name, ".timeout"}, 0, 1);
        check({name, ".nseg"}, r_cmd.size(), e_cmd.size());
        for (int s = 0; s < r_cmd.size() && s < e_cmd.size(); s++) begin
            check($sformatf("%s.cmd%0d", name, s), r_cmd[s], e_cmd[s]);
            check($sformatf("%s.dist%0d", name, s), r_dist[s], e_dist[s]);
            check($sformatf("%s.idx%0d", name, s), r_idx[s], e_idx[s]);
            check($sformatf("%s.len%0d", name, s), r_len[s], e_len[s]);
        end
        foreach (r_gap[g]) check($sformatf("%s.gap%0d", name, g), r_gap[g], 8);
        if (e_cmd.size() > 0) check({name, ".lead"}, lead, 1);
        check({name, ".stable"}, stable, 1);
        check({name, ".trail"}, zeros, e_trail);
        check({name, ".end_done"}, DONE, (e_end == 0) ? 1 : 0);
        check({name, ".end_busy"}, BUSY, 0);
        check({name, ".end_err"}, ERR_CODE, e_err);
        check({name, ".end_cmd"}, COMMAND, 0);
        check({name, ".end_dist"}, COMPARE_DISTANCE, 0);
        check({name, ".end_idx"}, STEP_INDEX, e_fidx);
        ABORT    = 1'b0;
        RUN_FLAG = 2'b10;
    endtask

    task automatic rst_midrun();
        RUN_FLAG = 2'b10;
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (6) @(negedge CLK);
        check("rst.pre_busy", BUSY, 1);
        check("rst.pre_cmd_active", (COMMAND != 8'h00), 1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("rst.cmd", COMMAND, 0);
        check("rst.dist", COMPARE_DISTANCE, 0);
        check("rst.idx", STEP_INDEX, 0);
        check("rst.busy", BUSY, 0);
        check("rst.done", DONE, 0);
        check("rst.err", ERR_CODE, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; PROG_WE = 1'b0; PROG_ADDR = '0; PROG_DATA = '0;
        START = 1'b0; ABORT = 1'b0; RUN_FLAG = 2'b10;
        repeat (3) @(negedge CLK);
        check("reset.cmd", COMMAND, 0);
        check("reset.dist", COMPARE_DISTANCE, 0);
        check("reset.idx", STEP_INDEX, 0);
        check("reset.busy", BUSY, 0);
        check("reset.done", DONE, 0);
        check("reset.err", ERR_CODE, 0);
        RST = 1'b0;

        fill_prog(1);
        prog_m[0] = {2'b01, 8'd140};
        ack_l[0] = 3; run_l[0] = 50;
        load_all();
        run_scn("single", 0);

        fill_prog(3);
        prog_m[0] = {2'b01, 8'd20};
        prog_m[1] = {2'b10, 8'd90};
        prog_m[2] = {2'b11, 8'd90};
        load_all();
        run_scn("three", 0);

        fill_prog(2);
        beh[0] = B_NOACK;
        load_all();
        run_scn("acktimeout", 0);

        fill_prog(3);
        beh[1] = B_ERR;
        load_all();
        run_scn("runerr", 0);
        run_scn("restart", 1);

        fill_prog(3);
        beh[0] = B_ABORT;
        load_all();
        run_scn("abort", 0);
        @(negedge CLK);
        START = 1'b1; ABORT = 1'b1;
        @(negedge CLK);
        START = 1'b0; ABORT = 1'b0;
        check("abort_start.busy", BUSY, 0);
        check("abort_start.cmd", COMMAND, 0);

        fill_prog(16);
        load_all();
        run_scn("full", 0);

        fill_prog(4);
        beh[2] = B_NORUN;
        load_all();
        run_scn("runtimeout", 0);

        fill_prog(5);
        load_all();
        rst_midrun();
        run_scn("after_rst", 0);

        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 16);
            fill_prog(n);
            if ($urandom_range(0, 1) == 1) beh[$urandom_range(0, n - 1)] = $urandom_range(1, 4);
            load_all();
            run_scn($sformatf("rand%0d", r), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
